// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: per-stage stall vector plus multi-cycle EX op FSM; PIPE_CTRL_PERF_EN adds an EX-stall counter.
// Latency: stall, mc_busy, mc_last and ex_hold are combinational from inputs and state; FSM and counter update on the next rising edge.
// Backpressure: stallreq_mem freezes the FSM and holds PC..MEM; flush overrides every request and abandons any op.
module pipe_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic        mc_start,
  input  logic [5:0]  mc_cycles,
  output logic [5:0]  stall,
  output logic        mc_busy,
  output logic        mc_last,
  output logic [5:0]  mc_cnt,
  output logic [31:0] perf_stall_cnt
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [5:0] cnt_nxt;
  logic       mc_go;
  logic       ex_hold;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mc_cnt <= 6'd0;
    end else begin
      state  <= state_nxt;
      mc_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    mc_busy = (state == BUSY);
    mc_last = (state == BUSY) && (mc_cnt == 6'd1);
    // zero-length ops never stall and never enter BUSY
    mc_go   = (state == IDLE) && mc_start && (mc_cycles != 6'd0);
    ex_hold = stallreq_ex || mc_go || (mc_busy && !mc_last);
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = mc_cnt;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 6'd0;
    end else begin
      case (state)
        IDLE: begin
          if (mc_go && !stallreq_mem) begin
            state_nxt = BUSY;
            cnt_nxt   = mc_cycles;
          end
        end
        BUSY: begin
          if (!stallreq_mem) begin
            if (mc_cnt == 6'd1) begin
              state_nxt = IDLE;
              cnt_nxt   = 6'd0;
            end else begin
              cnt_nxt = mc_cnt - 6'd1;
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 6'd0;
        end
      endcase
    end
  end

  always_comb begin
    stall = 6'b000000;
    if (!rst || flush) begin
      stall = 6'b000000;
    end else if (stallreq_mem) begin
      stall = 6'b011111;
    end else if (ex_hold) begin
      stall = 6'b001111;
    end else if (stallreq_id) begin
      stall = 6'b000111;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= 32'd0;
    end else if (stall[3] && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl with a queue-based scoreboard checked on the falling edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic [5:0]  stall;
  logic        mc_busy;
  logic        mc_last;
  logic [5:0]  mc_cnt;
  logic [31:0] perf_stall_cnt;

  typedef struct {
    int          idx;
    logic [5:0]  stall;
    logic        busy;
    logic        last;
    logic [5:0]  cnt;
    logic [31:0] perf;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   vec_idx  = 0;

  pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .stallreq_id    (stallreq_id),
    .stallreq_ex    (stallreq_ex),
    .stallreq_mem   (stallreq_mem),
    .mc_start       (mc_start),
    .mc_cycles      (mc_cycles),
    .stall          (stall),
    .mc_busy        (mc_busy),
    .mc_last        (mc_last),
    .mc_cnt         (mc_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, req);
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("stall",  e.idx, {26'd0, stall},  {26'd0, e.stall});
      check("busy",   e.idx, {31'd0, mc_busy}, {31'd0, e.busy});
      check("last",   e.idx, {31'd0, mc_last}, {31'd0, e.last});
      check("mc_cnt", e.idx, {26'd0, mc_cnt}, {26'd0, e.cnt});
      check("perf",   e.idx, perf_stall_cnt,  e.perf);
    end
  end

  // Drive one cycle of inputs just after the rising edge and queue the hand-computed outputs.
  // pf is the expected counter value when the perf counter is built in.
  task automatic step(input logic r, input logic fl, input logic id, input logic ex, input logic mem,
                      input logic st, input logic [5:0] cyc,
                      input logic [5:0] e_stall, input logic e_busy, input logic e_last,
                      input logic [5:0] e_cnt, input int pf);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; flush = fl; stallreq_id = id; stallreq_ex = ex; stallreq_mem = mem;
    mc_start = st; mc_cycles = cyc;
    e.idx   = vec_idx;
    e.stall = e_stall;
    e.busy  = e_busy;
    e.last  = e_last;
    e.cnt   = e_cnt;
`ifdef PIPE_CTRL_PERF_EN
    e.perf  = pf;
`else
    e.perf  = 32'd0;
`endif
    exp_q.push_back(e);
    vec_idx++;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0;
    stallreq_mem = 1'b0; mc_start = 1'b0; mc_cycles = 6'd0;

    //   rst fl id ex mem st cyc    stall      busy last cnt perf
    // reset holds everything at zero even with requests raised
    step(0, 0, 1, 1, 1, 1, 6'd3, 6'b000000, 0, 0, 6'd0, 0);
    step(0, 0, 1, 0, 1, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 0);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 0);
    // stall priority
    step(1, 0, 1, 1, 0, 0, 6'd0, 6'b001111, 0, 0, 6'd0, 0);
    step(1, 0, 1, 0, 0, 0, 6'd0, 6'b000111, 0, 0, 6'd0, 1);
    step(1, 0, 0, 1, 0, 0, 6'd0, 6'b001111, 0, 0, 6'd0, 1);
    step(1, 0, 0, 1, 1, 0, 6'd0, 6'b011111, 0, 0, 6'd0, 2);
    step(1, 1, 0, 1, 1, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 3);
    // single extra cycle op
    step(1, 0, 0, 0, 0, 1, 6'd1, 6'b001111, 0, 0, 6'd0, 3);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 1, 1, 6'd1, 4);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 4);
    // zero-length op ignored
    step(1, 0, 0, 0, 0, 1, 6'd0, 6'b000000, 0, 0, 6'd0, 4);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 4);
    // four-cycle op
    step(1, 0, 0, 0, 0, 1, 6'd4, 6'b001111, 0, 0, 6'd0, 4);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b001111, 1, 0, 6'd4, 5);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b001111, 1, 0, 6'd3, 6);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b001111, 1, 0, 6'd2, 7);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 1, 1, 6'd1, 8);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 8);
    // four-cycle op frozen two cycles at mc_cnt=3: counter gains 6
    step(1, 0, 0, 0, 0, 1, 6'd4, 6'b001111, 0, 0, 6'd0, 8);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b001111, 1, 0, 6'd4, 9);
    step(1, 0, 0, 0, 1, 0, 6'd0, 6'b011111, 1, 0, 6'd3, 10);
    step(1, 0, 0, 0, 1, 0, 6'd0, 6'b011111, 1, 0, 6'd3, 11);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b001111, 1, 0, 6'd3, 12);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b001111, 1, 0, 6'd2, 13);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 1, 1, 6'd1, 14);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 14);
    // flush while BUSY at mc_cnt=5
    step(1, 0, 0, 0, 0, 1, 6'd5, 6'b001111, 0, 0, 6'd0, 14);
    step(1, 1, 0, 0, 0, 0, 6'd0, 6'b000000, 1, 0, 6'd5, 15);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 15);
    // flush or mem-wait on the start cycle blocks entry to BUSY
    step(1, 1, 0, 0, 0, 1, 6'd3, 6'b000000, 0, 0, 6'd0, 15);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 15);
    step(1, 0, 0, 0, 1, 1, 6'd3, 6'b011111, 0, 0, 6'd0, 15);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 16);
    // mc_start while BUSY ignored
    step(1, 0, 0, 0, 0, 1, 6'd2, 6'b001111, 0, 0, 6'd0, 16);
    step(1, 0, 0, 0, 0, 1, 6'd9, 6'b001111, 1, 0, 6'd2, 17);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 1, 1, 6'd1, 18);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 18);
    // reset mid-op clears outputs before the next edge
    step(1, 0, 0, 0, 0, 1, 6'd5, 6'b001111, 0, 0, 6'd0, 18);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b001111, 1, 0, 6'd5, 19);
    step(0, 0, 1, 1, 1, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 0);
    step(0, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 0);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 0);
    step(1, 0, 0, 1, 0, 0, 6'd0, 6'b001111, 0, 0, 6'd0, 0);
    step(1, 0, 0, 0, 0, 0, 6'd0, 6'b000000, 0, 0, 6'd0, 1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-003 SHALL have port flush  input  1  synchronous pipeline flush (exception/redirect).
REQ-004 SHALL have port stallreq_id  input  1  ID-stage stall request (load-use).
REQ-005 SHALL have port stallreq_ex  input  1  EX-stage single-cycle stall request.
REQ-006 SHALL have port stallreq_mem  input  1  MEM-stage wait request.
REQ-007 SHALL have port mc_start  input  1  EX begins a multi-cycle operation this cycle.
REQ-008 SHALL have port mc_cycles  input  6  extra EX cycles required by the op, sampled when mc_start=1.
REQ-009 SHALL have port stall  output  6  per-stage hold: bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB.
REQ-010 SHALL have port mc_busy  output  1  FSM in BUSY.
REQ-011 SHALL have port mc_last  output  1  final cycle of the multi-cycle op; EX commits its result.
REQ-012 SHALL have port mc_cnt  output  6  remaining BUSY cycles, including the current one.
REQ-013 SHALL have port perf_stall_cnt  output  32  EX-stall cycle count (see Configuration).

Function
REQ-014 stall SHALL be combinational, priority flush > mem > ex > id: flush -> 6'b000000; stallreq_mem -> 6'b011111; ex_hold -> 6'b001111; stallreq_id -> 6'b000111; otherwise 6'b000000.
REQ-015 ex_hold SHALL equal stallreq_ex OR (IDLE AND mc_start AND mc_cycles!=0) OR (BUSY AND NOT mc_last).
REQ-016 FSM SHALL have two states: IDLE and BUSY.
REQ-017 IDLE->BUSY SHALL occur when mc_start=1, mc_cycles!=0, flush=0, stallreq_mem=0; mc_cnt loads mc_cycles.
REQ-018 mc_start with mc_cycles=0 SHALL be ignored (no stall, stays IDLE); mc_start while BUSY SHALL be ignored.
REQ-019 In BUSY with stallreq_mem=0, mc_cnt SHALL decrement by 1 per cycle; at mc_cnt=1 the FSM SHALL return to IDLE and mc_cnt become 0.
REQ-020 In BUSY with stallreq_mem=1, mc_cnt and state SHALL freeze.
REQ-021 mc_last SHALL be 1 exactly when BUSY and mc_cnt=1; mc_busy SHALL be 1 exactly when BUSY.
REQ-022 A multi-cycle op SHALL occupy EX for mc_cycles+1 unfrozen cycles: start cycle stalled, mc_cycles-1 stalled BUSY cycles, then one unstalled mc_last cycle.
REQ-023 flush=1 SHALL force next state IDLE and mc_cnt 0 regardless of other inputs.

Reset
REQ-024 While rst=0, state SHALL be IDLE, mc_cnt=0, mc_busy=0, mc_last=0, perf_stall_cnt=0, asynchronously.
REQ-025 stall SHALL be 6'b000000 while rst=0, regardless of request inputs.
REQ-026 Reset asserted mid-operation SHALL abandon the op; after release the FSM starts in IDLE.

Configuration
REQ-027 Macro PIPE_CTRL_PERF_EN defined: perf_stall_cnt SHALL increment by 1 each cycle stall[3]=1 and rst=1, saturating at 32'hFFFF_FFFF; flush does not clear it.
REQ-028 Macro PIPE_CTRL_PERF_EN undefined: perf_stall_cnt SHALL be constant 0 and no counter register exists.

Verification
REQ-029 mc_start=1, mc_cycles=1 (madd) -> start cycle stall=6'b001111; next cycle mc_last=1, stall=0; then IDLE.
REQ-030 mc_start=1, mc_cycles=4 -> stall=6'b001111 for 4 cycles, mc_cnt 4,3,2,1, mc_last on 4th BUSY cycle with stall=0.
REQ-031 BUSY mc_cnt=3, stallreq_mem=1 for 2 cycles -> stall=6'b011111, mc_cnt holds 3; then resumes 3,2,1.
REQ-032 stallreq_id=1 and stallreq_ex=1 together -> stall=6'b001111; stallreq_id alone -> 6'b000111.
REQ-033 BUSY mc_cnt=5, flush=1 -> stall=0 that cycle; next cycle IDLE, mc_cnt=0; rst=0 mid-op -> all outputs 0 immediately.
REQ-034 PIPE_CTRL_PERF_EN defined, op with mc_cycles=4 plus 2 mem-wait cycles -> perf_stall_cnt=6; undefined -> 0.
